// File: rtl/jtopl_eg_pkg.sv
// Shared constants and types for the OPL envelope final-stage slot controller.
// Optional feature macro used by the controller: JTOPL_EG_MUTE_EN.
package jtopl_eg_pkg;

    localparam int         EG_SLOTS_DEF = 18;
    localparam int         EG_SLOT_W    = 5;
    localparam logic [9:0] ATT_MAX      = 10'h3FF;

    typedef enum logic [1:0] {
        EG_SEL_KSLTL = 2'd0,
        EG_SEL_AM    = 2'd1,
        EG_SEL_RSV2  = 2'd2,
        EG_SEL_RSV3  = 2'd3
    } eg_sel_e;

    // Key-scale base level indexed by the top four F-number bits
    function automatic logic [6:0] ksl_lut(input logic [3:0] fnum);
        logic [6:0] v;
        case (fnum)
            4'd0:    v = 7'd0;
            4'd1:    v = 7'd32;
            4'd2:    v = 7'd40;
            4'd3:    v = 7'd45;
            4'd4:    v = 7'd48;
            4'd5:    v = 7'd51;
            4'd6:    v = 7'd53;
            4'd7:    v = 7'd55;
            4'd8:    v = 7'd56;
            4'd9:    v = 7'd58;
            4'd10:   v = 7'd59;
            4'd11:   v = 7'd60;
            4'd12:   v = 7'd61;
            4'd13:   v = 7'd62;
            4'd14:   v = 7'd63;
            default: v = 7'd64;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/jtopl_eg_final.sv
// Envelope final stage: adds TL, key-scale level and AM to the raw envelope
// attenuation and saturates the result to 10 bits.
module jtopl_eg_final
    import jtopl_eg_pkg::*;
(
    input  logic [3:0] lfo_mod,
    input  logic [3:0] fnum,
    input  logic [2:0] block,
    input  logic       amsen,
    input  logic       ams,
    input  logic [5:0] tl,
    input  logic [1:0] ksl,
    input  logic [9:0] eg_pure_in,
    output logic [9:0] eg_limited
);

    logic [7:0]  ksl_base;
    logic [8:0]  ksl_db;
    logic [5:0]  am_final;
    logic [11:0] sum_eg;

    // A negative base (low pitch, low block) means no key scaling at all
    always_comb begin
        ksl_base = {1'b0, ksl_lut(fnum)} - {1'b0, 4'd8 - {1'b0, block}, 3'b000};
        if (ksl_base[7] || ksl == 2'd0) begin
            ksl_db = '0;
        end else begin
            ksl_db = {ksl_base[6:0], 2'b00} >> ~ksl;
        end

        if (!amsen) begin
            am_final = '0;
        end else if (ams) begin
            am_final = {lfo_mod, 2'b00};
        end else begin
            am_final = {2'b00, lfo_mod};
        end

        sum_eg = {3'b000, tl, 3'b000} + {2'b00, ksl_db, 1'b0}
               + {2'b00, eg_pure_in} + {6'd0, am_final};

        eg_limited = (sum_eg[11:10] != 2'd0) ? ATT_MAX : sum_eg[9:0];
    end

endmodule

// File: rtl/jtopl_eg_slot_ctrl.sv
// Round-robin slot sequencer and per-slot TL/KSL/AM store feeding jtopl_eg_final.
// Optional per-slot mute input enabled by defining JTOPL_EG_MUTE_EN.
module jtopl_eg_slot_ctrl
    import jtopl_eg_pkg::*;
#(
    parameter int SLOTS = EG_SLOTS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic                 wr_en,
    input  logic [EG_SLOT_W-1:0] wr_slot,
    input  logic [1:0]           wr_sel,
    input  logic [7:0]           wr_din,
    input  logic                 ams,
    input  logic [3:0]           lfo_mod,
    input  logic [3:0]           fnum,
    input  logic [2:0]           block,
    input  logic [9:0]           eg_pure_in,
`ifdef JTOPL_EG_MUTE_EN
    input  logic [SLOTS-1:0]     mute_mask,
`endif
    output logic [EG_SLOT_W-1:0] cur_slot,
    output logic                 frame_start,
    output logic [9:0]           att,
    output logic [EG_SLOT_W-1:0] att_slot,
    output logic                 att_valid
);

    localparam logic [EG_SLOT_W-1:0] LAST_SLOT = EG_SLOT_W'(SLOTS - 1);

    logic [5:0]           tl_q    [SLOTS];
    logic [5:0]           tl_d    [SLOTS];
    logic [1:0]           ksl_q   [SLOTS];
    logic [1:0]           ksl_d   [SLOTS];
    logic                 amsen_q [SLOTS];
    logic                 amsen_d [SLOTS];

    logic [EG_SLOT_W-1:0] cur_slot_q, cur_slot_d;
    logic [EG_SLOT_W-1:0] att_slot_q, att_slot_d;
    logic                 frame_start_q, frame_start_d;
    logic                 att_valid_q, att_valid_d;
    logic [9:0]           att_q, att_d;
    logic [9:0]           eg_limited;
    logic                 mute;
    eg_sel_e              sel;

    // Slots outside 0..SLOTS-1 never match, so out-of-range writes are dropped
    always_comb begin
        sel = eg_sel_e'(wr_sel);
        for (int i = 0; i < SLOTS; i++) begin
            tl_d[i]    = tl_q[i];
            ksl_d[i]   = ksl_q[i];
            amsen_d[i] = amsen_q[i];
            if (wr_en && wr_slot == EG_SLOT_W'(i)) begin
                if (sel == EG_SEL_KSLTL) begin
                    ksl_d[i] = wr_din[7:6];
                    tl_d[i]  = wr_din[5:0];
                end else if (sel == EG_SEL_AM) begin
                    amsen_d[i] = wr_din[7];
                end
            end
        end
    end

`ifdef JTOPL_EG_MUTE_EN
    assign mute = mute_mask[cur_slot_q];
`else
    assign mute = 1'b0;
`endif

    // Reading the next-state store forwards a same-cycle write to the evaluated slot
    jtopl_eg_final u_final (
        .lfo_mod    (lfo_mod),
        .fnum       (fnum),
        .block      (block),
        .amsen      (amsen_d[cur_slot_q]),
        .ams        (ams),
        .tl         (tl_d[cur_slot_q]),
        .ksl        (ksl_d[cur_slot_q]),
        .eg_pure_in (eg_pure_in),
        .eg_limited (eg_limited)
    );

    always_comb begin
        cur_slot_d    = cur_slot_q;
        frame_start_d = frame_start_q;
        att_d         = att_q;
        att_slot_d    = att_slot_q;
        att_valid_d   = 1'b0;
        if (cen) begin
            cur_slot_d    = (cur_slot_q == LAST_SLOT) ? '0 : cur_slot_q + 1'b1;
            frame_start_d = (cur_slot_q == LAST_SLOT);
            att_d         = mute ? ATT_MAX : eg_limited;
            att_slot_d    = cur_slot_q;
            att_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_slot_q    <= '0;
            frame_start_q <= 1'b0;
            att_q         <= ATT_MAX;
            att_slot_q    <= '0;
            att_valid_q   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                tl_q[i]    <= '0;
                ksl_q[i]   <= '0;
                amsen_q[i] <= 1'b0;
            end
        end else begin
            cur_slot_q    <= cur_slot_d;
            frame_start_q <= frame_start_d;
            att_q         <= att_d;
            att_slot_q    <= att_slot_d;
            att_valid_q   <= att_valid_d;
            for (int i = 0; i < SLOTS; i++) begin
                tl_q[i]    <= tl_d[i];
                ksl_q[i]   <= ksl_d[i];
                amsen_q[i] <= amsen_d[i];
            end
        end
    end

    assign cur_slot    = cur_slot_q;
    assign frame_start = frame_start_q;
    assign att         = att_q;
    assign att_slot    = att_slot_q;
    assign att_valid   = att_valid_q;

endmodule
